// File: rtl/rpm_pwm.sv
// rtl/rpm_pwm.sv - single-motor PWM output stage with clamp, slew limit and arming hold
module rpm_pwm #(
   parameter int RPM_MAX     = 10000,
   parameter int RPM_MIN     = 1000,
   parameter int SLEW_STEP   = 100,
   parameter int ARM_PERIODS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] rpm_set,
   input  logic        arm,
   output logic        pwm_out,
   output logic [15:0] rpm_cmd,
   output logic        armed,
   output logic        period_end
);

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      RUN      = 2'd2
   } state_t;

   localparam logic [15:0]        MAX_C    = 16'(RPM_MAX);
   localparam logic [15:0]        MIN_C    = 16'(RPM_MIN);
   localparam logic [15:0]        STEP_C   = 16'(SLEW_STEP);
   localparam logic [15:0]        ARM_LAST = 16'(ARM_PERIODS - 1);
   localparam logic signed [16:0] MAX_S    = 17'(RPM_MAX);
   localparam logic signed [16:0] MIN_S    = 17'(RPM_MIN);

   state_t             state, state_nxt;
   logic [15:0]        cnt, cnt_nxt;
   logic [15:0]        arm_cnt, arm_cnt_nxt;
   logic [15:0]        cmd_nxt;
   logic [15:0]        target, slewed;
   logic signed [16:0] set_s;
   logic               wrap;

   assign wrap    = (cnt == MAX_C);
   assign cnt_nxt = wrap ? 16'd0 : cnt + 16'd1;
   assign set_s   = {rpm_set[15], rpm_set};

   // Negative commands fall below RPM_MIN in the signed view and clamp to idle.
   always_comb begin
      target = rpm_set;
      if (set_s < MIN_S)
         target = MIN_C;
      else if (set_s > MAX_S)
         target = MAX_C;
   end

   // Step is taken only when the gap exceeds it, so the result never passes target.
   always_comb begin
      slewed = rpm_cmd;
      if (target > rpm_cmd) begin
         if ((target - rpm_cmd) > STEP_C)
            slewed = rpm_cmd + STEP_C;
         else
            slewed = target;
      end else if (target < rpm_cmd) begin
         if ((rpm_cmd - target) > STEP_C)
            slewed = rpm_cmd - STEP_C;
         else
            slewed = target;
      end
   end

   always_comb begin
      state_nxt   = state;
      cmd_nxt     = rpm_cmd;
      arm_cnt_nxt = arm_cnt;
      if (!arm) begin
         state_nxt   = DISARMED;
         cmd_nxt     = 16'd0;
         arm_cnt_nxt = 16'd0;
      end else if (wrap) begin
         case (state)
            DISARMED: begin
               state_nxt   = ARMING;
               cmd_nxt     = MIN_C;
               arm_cnt_nxt = 16'd0;
            end
            ARMING: begin
               if (arm_cnt == ARM_LAST) begin
                  state_nxt   = RUN;
                  cmd_nxt     = slewed;
                  arm_cnt_nxt = 16'd0;
               end else begin
                  arm_cnt_nxt = arm_cnt + 16'd1;
               end
            end
            RUN: cmd_nxt = slewed;
            default: begin
               state_nxt   = DISARMED;
               cmd_nxt     = 16'd0;
               arm_cnt_nxt = 16'd0;
            end
         endcase
      end
   end

   // Outputs are registered from next-state values so they line up with cnt.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= DISARMED;
         cnt        <= 16'd0;
         arm_cnt    <= 16'd0;
         rpm_cmd    <= 16'd0;
         pwm_out    <= 1'b0;
         armed      <= 1'b0;
         period_end <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         arm_cnt    <= arm_cnt_nxt;
         rpm_cmd    <= cmd_nxt;
         pwm_out    <= (state_nxt != DISARMED) && (cnt_nxt < cmd_nxt);
         armed      <= (state_nxt == RUN);
         period_end <= (cnt_nxt == MAX_C);
      end
   end

endmodule
